aes_stream_packer: RTL and testbench
====================================

AES_STREAM_PACKER -- requirements
Module: aes_stream_packer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 64, the maximum number of cycles spent waiting for aes_ready after aes_start.
REQ-002 SHALL have port sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an input byte.
REQ-006 SHALL have port in_byte  input  8  plaintext byte.
REQ-007 SHALL have port iv  input  [0:127]  chaining initial value.
REQ-008 SHALL have port iv_load  input  1  load iv into the chain register.
REQ-009 SHALL have port aes_start  output  1  one-cycle start pulse to the AES cipher.
REQ-010 SHALL have port aes_text  output  [0:127]  block presented to the cipher text_in.
REQ-011 SHALL have port aes_ready  input  1  cipher ready/done.
REQ-012 SHALL have port aes_result  input  [0:127]  cipher text_out.
REQ-013 SHALL have port out_valid  output  1  ciphertext byte valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts a byte.
REQ-015 SHALL have port out_byte  output  8  ciphertext byte.
REQ-016 SHALL have port err  output  1  sticky cipher-timeout flag.

Function
REQ-017 SHALL implement the FSM states FILL, START, WAIT and DRAIN, with a 4-bit byte counter and a WAIT_LIMIT-wide wait counter.
REQ-018 SHALL, in FILL, drive in_ready=1 and, on in_valid&&in_ready, store in_byte into bits [8k:8k+7] of the block buffer, where k is the counter value (byte 0 at bits [0:7]), then increment the counter.
REQ-019 SHALL, on acceptance of the 16th byte (counter 15), wrap the counter to 0 and enter START on the next cycle.
REQ-020 SHALL, in START, drive aes_start=1 for exactly one cycle, then enter WAIT.
REQ-021 SHALL hold aes_text stable from START until leaving WAIT.
REQ-022 SHALL ignore aes_ready during the START cycle.
REQ-023 SHALL, in WAIT, capture aes_result on the first cycle aes_ready=1, then enter DRAIN; latency from 16th-byte acceptance to aes_start is 1 cycle.
REQ-024 SHALL, when WAIT lasts WAIT_LIMIT cycles without aes_ready, set err=1, discard the block and return to FILL.
REQ-025 SHALL keep err at 1 until reset.
REQ-026 SHALL, in DRAIN, drive out_valid=1 with out_byte equal to result byte k (bits [8k:8k+7]), and advance k on out_valid&&out_ready.
REQ-027 SHALL, after byte 15 is taken, return to FILL on the next cycle.
REQ-028 SHALL drive in_ready=0 in START, WAIT and DRAIN, so no input byte is lost or overwritten.
REQ-029 SHALL never present out_valid and in_ready high in the same cycle.
REQ-030 SHALL hold out_byte/out_valid stable while out_valid=1 and out_ready=0.
REQ-031 SHALL ignore iv_load except in FILL with counter 0; when iv_load and in_valid coincide there, the iv load and the byte acceptance both take effect.

Reset
REQ-032 SHALL, when sys_rst_n=0 at a clock edge, including mid-block in any state, enter FILL.
REQ-033 SHALL, on that reset, clear the counters, buffer, result register, chain register and err.
REQ-034 SHALL, after reset, drive in_ready=1 and aes_start=0, out_valid=0, out_byte=0, aes_text=0 and err=0.
REQ-035 SHALL discard any partial block on reset.

Configuration
REQ-036 SHALL, with macro AES_STREAM_CBC_EN defined, drive aes_text = buffer XOR chain.
REQ-037 SHALL, with AES_STREAM_CBC_EN defined, load chain from iv on iv_load and from aes_result on each capture, implementing CBC encryption.
REQ-038 SHALL, without AES_STREAM_CBC_EN, drive aes_text = buffer (ECB), ignore iv and iv_load, and omit the chain register; ports remain present.

Verification
REQ-039 SHALL cover: key 000102..0f on the attached cipher, feed bytes 00 11 22 .. ff (ECB) -> out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
REQ-040 SHALL cover: out_ready held 0 for 10 cycles in DRAIN -> out_byte stays 69, in_ready stays 0, and no byte is dropped after release.
REQ-041 SHALL cover: aes_ready stuck 0 -> after 64 WAIT cycles err=1, in_ready=1, and the next 16 bytes process normally with err still 1.
REQ-042 SHALL cover: sys_rst_n=0 after 7 input bytes -> in_ready=1, counter 0, and the next 16 bytes form a fresh block that yields the correct ciphertext.
REQ-043 SHALL cover: AES_STREAM_CBC_EN with iv=0 and the REQ-039 plaintext sent twice -> first block 69c4..c55a, second block equals AES(plaintext XOR 69c4e0d86a7b0430d8cdb78070b4c55a).
REQ-044 SHALL cover: iv_load asserted in DRAIN with AES_STREAM_CBC_EN -> ignored, and chaining uses the previous ciphertext.

Source files
------------

// File: rtl/aes_stream_packer.sv
// Packs a byte stream into 128-bit blocks for an external AES core and streams the
// ciphertext back out byte by byte. Define AES_STREAM_CBC_EN for CBC chaining (default ECB).
module aes_stream_packer #(
   parameter int WAIT_LIMIT = 64
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     in_byte,
   input  logic [0:127]   iv,
   input  logic           iv_load,
   output logic           aes_start,
   output logic [0:127]   aes_text,
   input  logic           aes_ready,
   input  logic [0:127]   aes_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     out_byte,
   output logic           err,
   output logic [1:0]     dbg_state
);

   // Handshakes: a byte moves on a port only in a cycle where its valid and ready are both 1;
   // in_ready and out_valid depend only on the FSM state, never on the partner's signal.

   localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic [0:127]   buf_q, buf_d;
   logic [0:127]   res_q, res_d;
   logic           err_q, err_d;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         wait_q  <= '0;
         buf_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         buf_q   <= buf_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      buf_d     = buf_q;
      res_d     = res_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      aes_start = 1'b0;
      out_valid = 1'b0;
      out_byte  = 8'h00;
      case (state_q)
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_d[{cnt_q, 3'b000} +: 8] = in_byte;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = S_START;
            end
         end
         S_START: begin
            aes_start = 1'b1;
            wait_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (aes_ready) begin
               res_d   = aes_result;
               state_d = S_DRAIN;
            end else if (wait_q == WAIT_LAST) begin
               // Cipher never answered: drop the block, flag it, keep the stream alive.
               err_d   = 1'b1;
               state_d = S_FILL;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_byte  = res_q[{cnt_q, 3'b000} +: 8];
            if (out_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

`ifdef AES_STREAM_CBC_EN
   logic [0:127] chain_q, chain_d;

   always_comb begin
      chain_d = chain_q;
      if (state_q == S_FILL && cnt_q == 4'd0 && iv_load) chain_d = iv;
      if (state_q == S_WAIT && aes_ready) chain_d = aes_result;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) chain_q <= '0;
      else            chain_q <= chain_d;
   end

   assign aes_text = buf_q ^ chain_q;
`else
   logic unused_iv;
   assign unused_iv = ^{iv, iv_load};
   assign aes_text  = buf_q;
`endif

   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Scoreboard bench for aes_stream_packer with a behavioural cipher responder.
// Build with +define+AES_STREAM_CBC_EN to exercise the CBC variant.
module tb_aes_stream_packer;

   localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] PT2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [0:127] IV1 = 128'h0123456789abcdeffedcba9876543210;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_byte = 8'h00;
   logic [0:127] iv = '0;
   logic         iv_load = 1'b0;
   logic         aes_start;
   logic [0:127] aes_text;
   logic         aes_ready = 1'b0;
   logic [0:127] aes_result = '1;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [7:0]   out_byte;
   logic         err;
   logic [1:0]   dbg_state;

   int total = 0;
   int bad = 0;
   logic         stuck = 1'b0;
   logic [0:127] chain_m = '0;
   logic [7:0]   exp_q[$];
   logic [0:127] txt_q[$];

   aes_stream_packer #(.WAIT_LIMIT(64)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .iv(iv), .iv_load(iv_load),
      .aes_start(aes_start), .aes_text(aes_text), .aes_ready(aes_ready), .aes_result(aes_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
      .err(err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in cipher: the FIPS-197 vector for key 000102..0f, else a fixed scramble.
   function automatic logic [0:127] cipher(input logic [0:127] x);
      if (x == PT) return CT;
      return {x[64:127], x[0:63]} ^ 128'h5a5a_3c3c_a5a5_c3c3_0f0f_f0f0_1234_5678;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int guard;
      in_valid = 1'b1;
      in_byte  = b;
      guard    = 0;
      forever begin
         @(negedge sys_clk);
         if (in_ready) begin
            @(posedge sys_clk);
            #1;
            break;
         end
         guard++;
         if (guard > 300) begin
            chk("in_ready_timeout", 1'b0, 1'b1);
            break;
         end
      end
      in_valid = 1'b0;
      iv_load  = 1'b0;
   endtask

   task automatic run_block(input logic [0:127] pt, input logic timeout, input logic load_iv);
      logic [0:127] text;
      logic [0:127] ct;
      if (load_iv) begin
         iv = IV1;
         iv_load = 1'b1;
`ifdef AES_STREAM_CBC_EN
         chain_m = IV1;
`endif
      end
`ifdef AES_STREAM_CBC_EN
      text = pt ^ chain_m;
`else
      text = pt;
`endif
      ct = cipher(text);
      txt_q.push_back(text);
      if (!timeout) begin
         for (int i = 0; i < 16; i++) exp_q.push_back(ct[8*i +: 8]);
`ifdef AES_STREAM_CBC_EN
         chain_m = ct;
`endif
      end
      for (int i = 0; i < 16; i++) send_byte(pt[8*i +: 8]);
      @(negedge sys_clk);
      chk("start_latency", aes_start, 1'b1);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!(exp_q.size() == 0 && in_ready)) begin
         @(negedge sys_clk);
         guard++;
         if (guard > 500) begin
            chk("drain_timeout", 1'b0, 1'b1);
            break;
         end
      end
      @(posedge sys_clk);
      #1;
   endtask

   // ---------------- cipher responder ----------------
   initial begin
      logic [0:127] captured;
      forever begin
         @(negedge sys_clk);
         if (aes_start) begin
            if (txt_q.size() == 0) begin
               chk("unexpected_start", 1'b1, 1'b0);
               captured = aes_text;
            end else begin
               captured = txt_q.pop_front();
               chk("aes_text", aes_text, captured);
            end
            if (!stuck) begin
               repeat ($urandom_range(1, 5)) @(negedge sys_clk);
               chk("aes_text_stable", aes_text, captured);
               @(posedge sys_clk);
               #1;
               aes_ready  = 1'b1;
               aes_result = cipher(captured);
               @(posedge sys_clk);
               #1;
               aes_ready  = 1'b0;
               aes_result = '1;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(negedge sys_clk);
         if (out_valid) begin
            chk("no_in_ready_with_out_valid", in_ready, 1'b0);
            if (out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_out_byte", 1'b1, 1'b0);
               else chk("out_byte", out_byte, exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_aes_start", aes_start, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_byte", out_byte, 8'h00);
      chk("rst_aes_text", aes_text, '0);
      chk("rst_err", err, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      @(posedge sys_clk);
      #1;

      // Known-answer block (ECB: 69c4...c55a; CBC from iv=0 gives the same first block).
      run_block(PT, 1'b0, 1'b0);
      wait_idle();

      // Same plaintext again, with a 10-cycle downstream stall and a stray iv_load in DRAIN.
      out_ready = 1'b0;
      run_block(PT, 1'b0, 1'b0);
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(negedge sys_clk);
         guard++;
      end
      chk("reach_drain", out_valid, 1'b1);
      @(posedge sys_clk);
      #1;
      iv = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      iv_load = 1'b1;
      @(posedge sys_clk);
      #1;
      iv_load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         chk("stall_out_byte_hold", {out_valid, out_byte}, {1'b1, exp_q[0]});
         chk("stall_in_ready_low", in_ready, 1'b0);
      end
      @(posedge sys_clk);
      #1;
      out_ready = 1'b1;
      wait_idle();

      // A second, distinct plaintext.
      run_block(PT2, 1'b0, 1'b0);
      wait_idle();

      // Cipher never answers: err after exactly 64 WAIT cycles, block dropped.
      stuck = 1'b1;
      run_block(PT2, 1'b1, 1'b0);
      repeat (64) @(negedge sys_clk);
      chk("err_before_limit", err, 1'b0);
      @(negedge sys_clk);
      chk("err_after_limit", err, 1'b1);
      chk("in_ready_after_timeout", in_ready, 1'b1);
      stuck = 1'b0;
      @(posedge sys_clk);
      #1;
      run_block(PT, 1'b0, 1'b0);
      wait_idle();
      chk("err_sticky", err, 1'b1);

      // Reset in the middle of a block.
      for (int i = 0; i < 7; i++) send_byte(PT2[8*i +: 8]);
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      chain_m = '0;
      @(negedge sys_clk);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_aes_text", aes_text, '0);
      chk("midrst_err", err, 1'b0);
      chk("midrst_state", dbg_state, 2'd0);
      @(posedge sys_clk);
      #1;
      run_block(PT, 1'b0, 1'b0);
      wait_idle();

      // iv_load together with the first byte of a block (takes effect only with CBC).
      run_block(PT2, 1'b0, 1'b1);
      wait_idle();
      run_block(PT2, 1'b0, 1'b0);
      wait_idle();

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("cipher_queue_empty", txt_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
